host_seq: RTL and testbench

- Host-side initiator for the processor's req/done handshake; the other end of the core's `req`/`done` interface.
- Per job: preload data memory from an input stream, hold the core in reset, pulse `req`, wait for `done` with a timeout, then stream result words back out.
- Sits beside top_level in the system wrapper and owns the data-memory write/read port whenever the core is not running.

---
 rtl/host_seq_pkg.sv | 20 ++
 rtl/host_seq.sv | 140 ++++++++++++++
 tb/tb_host_seq.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/host_seq_pkg.sv
// Shared types and default layout constants for the host-side job sequencer.
package host_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    RUN,
    DRAIN
  } state_t;

  // Processor data-memory layout: preload 0..63, results at 64/65.
  localparam int unsigned DEF_LOAD_BASE = 0;
  localparam int unsigned DEF_LOAD_LEN  = 64;
  localparam int unsigned DEF_RES_BASE  = 64;
  localparam int unsigned DEF_RES_LEN   = 2;

  typedef logic [7:0] word_t;

endpackage

// File: rtl/host_seq.sv
// Host-side initiator for the core req/done handshake: preloads data memory,
// holds the core in reset, pulses req, waits for done with a timeout and
// streams the result words back out.
module host_seq
  import host_seq_pkg::*;
#(
  parameter int unsigned AW        = 8,
  parameter int unsigned LOAD_BASE = DEF_LOAD_BASE,
  parameter int unsigned LOAD_LEN  = DEF_LOAD_LEN,
  parameter int unsigned RES_BASE  = DEF_RES_BASE,
  parameter int unsigned RES_LEN   = DEF_RES_LEN,
  parameter int unsigned RST_CYC   = 2,
  parameter int unsigned TIMEOUT   = 4096,
  parameter int unsigned CW        = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  word_t         in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output word_t         out_data,
  output logic          core_reset,
  output logic          core_req,
  input  logic          core_done,
  output logic          mem_sel,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output word_t         mem_wr_data,
  input  word_t         mem_rd_data,
  output logic          busy,
  output logic          job_done,
  output logic          err_timeout,
  output logic [CW-1:0] run_cycles
);

  localparam logic [15:0]   LOAD_LAST   = 16'(LOAD_LEN - 1);
  localparam logic [15:0]   RES_LAST    = 16'(RES_LEN - 1);
  localparam logic [15:0]   SETTLE_LAST = 16'(RST_CYC - 1);
  localparam logic [CW-1:0] RUN_LAST    = CW'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] idx;
  logic [15:0] cnt;

  // Job sequencing: one shared word index, one settle counter, one run counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      run_cycles  <= '0;
      core_req    <= 1'b0;
      job_done    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      core_req <= 1'b0;
      job_done <= 1'b0;
      unique case (state)
        IDLE: begin
          // job_done cycle still counts as busy, so a start there is dropped
          if (start && !job_done) begin
            idx         <= '0;
            cnt         <= '0;
            err_timeout <= 1'b0;
            run_cycles  <= '0;
            state       <= (LOAD_LEN == 0) ? SETTLE : LOAD;
          end
        end
        LOAD: begin
          if (in_valid) begin
            if (idx == LOAD_LAST) begin
              state <= SETTLE;
              cnt   <= '0;
            end else begin
              idx <= idx + 16'd1;
            end
          end
        end
        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state      <= RUN;
            run_cycles <= '0;
            core_req   <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RUN: begin
          run_cycles <= run_cycles + 1'b1;
          // done is ignored in the req cycle; done beats a same-cycle timeout
          if (run_cycles != '0 && core_done) begin
            state <= DRAIN;
            idx   <= '0;
          end else if (run_cycles == RUN_LAST) begin
            state       <= IDLE;
            err_timeout <= 1'b1;
            job_done    <= 1'b1;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (idx == RES_LAST) begin
              state    <= IDLE;
              job_done <= 1'b1;
            end else begin
              idx <= idx + 16'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // State-decoded handshake and ownership signals.
  always_comb begin
    in_ready    = (state == LOAD);
    mem_wr_en   = (state == LOAD) && in_valid;
    mem_wr_data = in_data;
    out_valid   = (state == DRAIN);
    out_data    = mem_rd_data;
    core_reset  = (state != RUN);
    mem_sel     = (state != RUN);
    busy        = (state != IDLE) || job_done;
  end

  // Memory address: base plus shared index, wrapping at 2^AW.
  always_comb begin
    mem_addr = '0;
    case (state)
      LOAD:    mem_addr = AW'(LOAD_BASE + {16'd0, idx});
      DRAIN:   mem_addr = AW'(RES_BASE + {16'd0, idx});
      default: mem_addr = '0;
    endcase
  end

endmodule

// File: tb/tb_host_seq.sv
// Directed bench for host_seq: memory model, core model and drain consumer.
module tb_host_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, in_valid;
  logic [7:0] in_data;
  logic       out_ready = 1'b1;
  logic       core_done = 1'b0;
  logic [7:0] mem_rd_data;
  logic       in_ready, out_valid, core_reset, core_req, mem_sel, mem_wr_en;
  logic [7:0] out_data, mem_addr, mem_wr_data;
  logic       busy, job_done, err_timeout;
  logic [15:0] run_cycles;

  logic       z_start, z_in_valid;
  logic [7:0] z_in_data;
  logic       z_out_ready = 1'b1;
  logic       z_core_done = 1'b1;
  logic [7:0] z_mem_rd_data;
  logic       z_in_ready, z_out_valid, z_core_reset, z_core_req, z_mem_sel, z_mem_wr_en;
  logic [7:0] z_out_data, z_mem_addr, z_mem_wr_data;
  logic       z_busy, z_job_done, z_err;
  logic [15:0] z_run_cycles;

  host_seq #(.AW(8), .LOAD_BASE(0), .LOAD_LEN(4), .RES_BASE(64), .RES_LEN(2),
             .RST_CYC(2), .TIMEOUT(20), .CW(16)) u_dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .core_reset(core_reset), .core_req(core_req), .core_done(core_done), .mem_sel(mem_sel),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data), .busy(busy), .job_done(job_done),
    .err_timeout(err_timeout), .run_cycles(run_cycles));

  host_seq #(.AW(8), .LOAD_BASE(0), .LOAD_LEN(0), .RES_BASE(64), .RES_LEN(2),
             .RST_CYC(2), .TIMEOUT(20), .CW(16)) u_dut0 (
    .clk(clk), .reset(reset), .start(z_start), .in_valid(z_in_valid), .in_ready(z_in_ready),
    .in_data(z_in_data), .out_valid(z_out_valid), .out_ready(z_out_ready), .out_data(z_out_data),
    .core_reset(z_core_reset), .core_req(z_core_req), .core_done(z_core_done), .mem_sel(z_mem_sel),
    .mem_wr_en(z_mem_wr_en), .mem_addr(z_mem_addr), .mem_wr_data(z_mem_wr_data),
    .mem_rd_data(z_mem_rd_data), .busy(z_busy), .job_done(z_job_done),
    .err_timeout(z_err), .run_cycles(z_run_cycles));

  // data memory model: synchronous write, combinational read
  logic [7:0] mem [256];
  assign mem_rd_data   = mem[mem_addr];
  assign z_mem_rd_data = z_mem_addr ^ 8'h3C;
  always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_wr_data;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0]  wv [4]      = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0]  exp_res [2] = '{8'hA5, 8'h5A};
  logic [15:0] wlog [$];
  logic [7:0]  olog [$];
  logic [7:0]  z_olog [$];
  int run_idx = 0, done_at = 0, dcyc = 0;
  bit stale = 1'b0, bp = 1'b0;
  int req_cnt, rc_cnt, sel0_cnt, ov_cnt, jd_cnt, z_wr_cnt;

  // core model, drain consumer and observation, all at the falling edge
  initial forever begin
    @(negedge clk);
    run_idx   = core_reset ? 0 : run_idx + 1;
    core_done = core_reset ? stale : ((run_idx == done_at) || (stale && run_idx == 1));
    dcyc      = out_valid ? dcyc + 1 : 0;
    out_ready = !(bp && dcyc >= 2 && dcyc <= 4);
    if (mem_wr_en) wlog.push_back({mem_addr, mem_wr_data});
    if (core_req) req_cnt++;
    if (!core_reset) rc_cnt++;
    if (!mem_sel) sel0_cnt++;
    if (job_done) jd_cnt++;
    if (out_valid) begin
      ov_cnt++;
      if (olog.size() < 2) check("out_data", out_data, exp_res[olog.size()]);
      else check("out_extra", 1, 0);
      if (out_ready) olog.push_back(out_data);
    end
    if (z_mem_wr_en) z_wr_cnt++;
    if (z_out_valid && z_out_ready) z_olog.push_back(z_out_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int d, input bit s, input bit b);
    done_at = d; stale = s; bp = b;
    wlog.delete(); olog.delete();
    req_cnt = 0; rc_cnt = 0; sel0_cnt = 0; ov_cnt = 0; jd_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input bit toggle);
    int i = 0;
    int cyc = 0;
    bit v, rdy;
    while (i < 4 && cyc < 100) begin
      v        = toggle ? (cyc % 2 == 0) : 1'b1;
      in_valid = v;
      in_data  = v ? wv[i] : 8'hEE;
      rdy      = in_ready;
      tick();
      if (v && rdy) i++;
      cyc++;
    end
    in_valid = 1'b0;
    if (i < 4) check("feed_wait", 0, 1);
  endtask

  task automatic wait_jd(input bit poke);
    int c = 0;
    while (!job_done && c < 400) begin
      start = poke && (run_idx == 3);
      tick();
      c++;
    end
    start = 1'b0;
    if (!job_done) check("jd_wait", 0, 1);
  endtask

  task automatic finish_good(input int rc, input bit start_on_jd, input int ov);
    check("busy_at_jd", busy, 1);
    check("err_timeout", err_timeout, 0);
    check("run_cycles", run_cycles, rc);
    check("wr_count", wlog.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < wlog.size()) check("wr_beat", wlog[i], {8'(i), wv[i]});
    check("req_count", req_cnt, 1);
    check("run_len", rc_cnt, rc);
    check("sel0_len", sel0_cnt, rc);
    check("out_count", olog.size(), 2);
    check("ov_cycles", ov_cnt, ov);
    start = start_on_jd;
    tick();
    start = 1'b0;
    check("jd_pulse", job_done, 0);
    check("busy_after", busy, 0);
    check("jd_count", jd_cnt, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    z_start = 1'b0; z_in_valid = 1'b1; z_in_data = 8'h99;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[64] = 8'hA5;
    mem[65] = 8'h5A;
    repeat (3) tick();

    check("rst_core_reset", core_reset, 1);
    check("rst_core_req", core_req, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_job_done", job_done, 0);
    check("rst_err", err_timeout, 0);
    check("rst_run_cycles", run_cycles, 0);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_mem_sel", mem_sel, 1);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    tick();

    // nominal job
    start_job(10, 0, 0); feed(0); wait_jd(0); finish_good(10, 0, 2);
    // input gaps and drain stall
    start_job(10, 0, 1); feed(1); wait_jd(0); finish_good(10, 0, 5);
    // done in the last allowed RUN cycle wins over timeout
    start_job(20, 0, 0); feed(0); wait_jd(0); finish_good(20, 0, 2);

    // timeout
    start_job(0, 0, 0); feed(0); wait_jd(0);
    check("to_err", err_timeout, 1);
    check("to_run_cycles", run_cycles, 20);
    check("to_run_len", rc_cnt, 20);
    check("to_ov", ov_cnt, 0);
    check("to_wr_count", wlog.size(), 4);
    tick();
    check("to_jd_count", jd_cnt, 1);
    check("to_busy_after", busy, 0);
    check("to_err_sticky", err_timeout, 1);
    start_job(10, 0, 0);
    check("restart_err_clr", err_timeout, 0);
    check("restart_rc_clr", run_cycles, 0);
    feed(0); wait_jd(0); finish_good(10, 0, 2);

    // stale done through preload/settle and in the req cycle
    start_job(5, 1, 0); feed(0); wait_jd(0); finish_good(5, 0, 2);

    // start during RUN and on the job_done cycle are both dropped
    start_job(10, 0, 0); feed(0); wait_jd(1); finish_good(10, 1, 2);
    repeat (3) tick();
    check("idle_after_pokes", busy, 0);

    // reset during RUN cycle 3
    start_job(0, 0, 0); feed(0);
    begin
      int c = 0;
      while (run_idx != 2 && c < 100) begin tick(); c++; end
      if (run_idx != 2) check("run3_wait", 0, 1);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_core_reset", core_reset, 1);
    check("mid_rst_core_req", core_req, 0);
    repeat (3) tick();
    check("mid_rst_no_jd", jd_cnt, 0);
    start_job(10, 0, 0); feed(0); wait_jd(0); finish_good(10, 0, 2);

    // LOAD_LEN=0 instance: straight to SETTLE, no writes
    z_wr_cnt = 0;
    z_olog.delete();
    z_start = 1'b1;
    tick();
    z_start = 1'b0;
    check("z_in_ready", z_in_ready, 0);
    check("z_busy", z_busy, 1);
    check("z_core_reset", z_core_reset, 1);
    begin
      int c = 0;
      while (!z_job_done && c < 100) begin tick(); c++; end
      if (!z_job_done) check("z_jd_wait", 0, 1);
    end
    check("z_run_cycles", z_run_cycles, 2);
    check("z_wr_count", z_wr_cnt, 0);
    check("z_err", z_err, 0);
    check("z_out_count", z_olog.size(), 2);
    if (z_olog.size() == 2) begin
      check("z_out0", z_olog[0], 8'h7C);
      check("z_out1", z_olog[1], 8'h7D);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
